// File: rtl/maze_pkg.sv
// Maze constants shared by the tile arbiter, ghost and Pac-Man controllers.
// Direction codes double as the neighbour slot order.
package maze_pkg;

    localparam int XTILES = 30;
    localparam int YTILES = 33;

    typedef enum logic [1:0] {
        WALL = 2'b00,
        WKNP = 2'b01,
        WKRP = 2'b10,
        WKGH = 2'b11
    } tile_e;

    typedef enum logic [1:0] {
        DIR_RT = 2'b00,
        DIR_UP = 2'b01,
        DIR_DN = 2'b10,
        DIR_LT = 2'b11
    } dir_e;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_LAST  = 2'd2;

    function automatic logic [7:0] pack_tiles(input logic [1:0] rt, input logic [1:0] up,
                                              input logic [1:0] dn, input logic [1:0] lt);
        return {lt, dn, up, rt};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request strictly after 'last', wrapping.
module rr_arbiter #(
    parameter int N  = 5,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] id
);

    logic found;
    int   idx;

    always_comb begin
        gnt   = '0;
        id    = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 1; i <= N; i++) begin
            idx = (int'(last) + i) % N;
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                id       = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/maze_tile_arbiter.sv
// Shares the maze tile memory among Pac-Man and the ghosts: round-robin grant,
// four neighbour reads per grant, results held per requester in tile_info.
//
//   state    | meaning
//   ST_IDLE  | waiting for any req; grant and latch coordinates
//   ST_FETCH | k=0..3 drives neighbour address, captures previous slot
//   ST_LAST  | captures slot 3, writes tile_info[id], pulses done[id]
module maze_tile_arbiter import maze_pkg::*; #(
    parameter int N_REQ  = 5,
    parameter int XTILES = maze_pkg::XTILES,
    parameter int YTILES = maze_pkg::YTILES,
    parameter int AW     = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*7-1:0] xtile,
    input  logic [N_REQ*7-1:0] ytile,
    output logic [N_REQ-1:0]   done,
    output logic [N_REQ*8-1:0] tile_info,
    output logic               busy,
    output logic               mem_en,
    output logic [AW-1:0]      mem_addr,
    input  logic [1:0]         mem_rdata
);

    localparam int IW = $clog2(N_REQ);

    logic [1:0]       state_q;
    logic [1:0]       k_q;
    logic [IW-1:0]    id_q;
    logic [IW-1:0]    last_q;
    logic [N_REQ-1:0] gnt_q;
    logic [6:0]       x_q;
    logic [6:0]       y_q;
    logic             in_range_q;
    logic             prev_ok_q;
    logic [5:0]       slot_q;

    logic [N_REQ-1:0] gnt;
    logic [IW-1:0]    gnt_id;
    logic [6:0]       wx;
    logic [6:0]       wy;
    logic [6:0]       nx;
    logic [6:0]       ny;
    logic             slot_ok;
    logic [AW-1:0]    nb_addr;
    logic [1:0]       last_slot;

    rr_arbiter #(.N(N_REQ), .IW(IW)) u_rr (
        .req  (req),
        .last (last_q),
        .gnt  (gnt),
        .id   (gnt_id)
    );

    assign wx = xtile[7*int'(gnt_id) +: 7];
    assign wy = ytile[7*int'(gnt_id) +: 7];

    // Horizontal neighbours wrap through the tunnel; vertical ones past the edge read as wall.
    always_comb begin
        nx      = x_q;
        ny      = y_q;
        slot_ok = in_range_q;
        case (dir_e'(k_q))
            DIR_RT: nx = (x_q == 7'(XTILES-1)) ? 7'd0 : x_q + 7'd1;
            DIR_UP: begin
                ny      = y_q - 7'd1;
                slot_ok = in_range_q && (y_q != 7'd0);
            end
            DIR_DN: begin
                ny      = y_q + 7'd1;
                slot_ok = in_range_q && (y_q < 7'(YTILES-1));
            end
            default: nx = (x_q == 7'd0) ? 7'(XTILES-1) : x_q - 7'd1;
        endcase
    end

    assign nb_addr   = AW'(ny) * AW'(XTILES) + AW'(nx);
    assign mem_en    = (state_q == ST_FETCH) && slot_ok;
    assign mem_addr  = mem_en ? nb_addr : '0;
    assign busy      = (state_q != ST_IDLE);
    assign last_slot = prev_ok_q ? mem_rdata : WALL;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            k_q        <= '0;
            id_q       <= '0;
            last_q     <= IW'(N_REQ-1);
            gnt_q      <= '0;
            x_q        <= '0;
            y_q        <= '0;
            in_range_q <= 1'b0;
            prev_ok_q  <= 1'b0;
            slot_q     <= '0;
            done       <= '0;
            tile_info  <= '0;
        end else begin
            done <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (|req) begin
                        id_q       <= gnt_id;
                        last_q     <= gnt_id;
                        gnt_q      <= gnt;
                        x_q        <= wx;
                        y_q        <= wy;
                        in_range_q <= (wx < 7'(XTILES)) && (wy < 7'(YTILES));
                        k_q        <= '0;
                        state_q    <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    // Read data lags the address by one cycle, so slot k-1 lands now.
                    if (k_q != 2'd0) begin
                        slot_q[2*(int'(k_q)-1) +: 2] <= last_slot;
                    end
                    prev_ok_q <= slot_ok;
                    k_q       <= k_q + 2'd1;
                    if (k_q == 2'd3) begin
                        state_q <= ST_LAST;
                    end
                end
                ST_LAST: begin
                    tile_info[8*int'(id_q) +: 8] <= pack_tiles(slot_q[1:0], slot_q[3:2],
                                                               slot_q[5:4], last_slot);
                    done    <= gnt_q;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_maze_tile_arbiter.sv
// Self-checking bench for maze_tile_arbiter: per-cycle reference model plus directed scenarios.
module tb_maze_tile_arbiter;

    localparam int NR = 5;
    localparam int XT = 30;
    localparam int YT = 33;
    localparam int AW = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req;
    logic [NR*7-1:0]   xtile;
    logic [NR*7-1:0]   ytile;
    logic [NR-1:0]     done;
    logic [NR*8-1:0]   tile_info;
    logic              busy;
    logic              mem_en;
    logic [AW-1:0]     mem_addr;
    logic [1:0]        mem_rdata;

    always #5 clk = ~clk;

    maze_tile_arbiter #(.N_REQ(NR), .XTILES(XT), .YTILES(YT), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .xtile     (xtile),
        .ytile     (ytile),
        .done      (done),
        .tile_info (tile_info),
        .busy      (busy),
        .mem_en    (mem_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata)
    );

    // Memory content is addr[1:0]; a non-wall value when not enabled exposes unforced slots.
    always @(posedge clk) mem_rdata <= mem_en ? mem_addr[1:0] : 2'b11;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int addr_log[$];
    int done_cyc[$];
    int done_id[$];
    bit en_hist[4096];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: neighbour address from plain arithmetic, -1 when the slot reads as wall.
    function automatic int nb_addr(input int x, input int y, input int s);
        int dx, dy, nx, ny;
        dx = (s == 0) ? 1 : (s == 3) ? -1 : 0;
        dy = (s == 1) ? -1 : (s == 2) ? 1 : 0;
        if (x >= XT || y >= YT) return -1;
        nx = (x + dx + XT) % XT;
        ny = y + dy;
        if (ny < 0 || ny >= YT) return -1;
        return ny * XT + nx;
    endfunction

    function automatic logic [7:0] nb_tile(input int x, input int y);
        logic [7:0] t;
        int a;
        t = '0;
        for (int s = 0; s < 4; s++) begin
            a = nb_addr(x, y, s);
            if (a >= 0) t[2*s +: 2] = 2'(a % 4);
        end
        return t;
    endfunction

    function automatic int pick(input logic [NR-1:0] r, input int last);
        int j;
        for (int i = 1; i <= NR; i++) begin
            j = (last + i) % NR;
            if (r[j]) return j;
        end
        return 0;
    endfunction

    int            m_phase, m_last, m_id, m_x, m_y;
    logic [7:0]    m_tile [NR];
    logic [NR-1:0] m_done;

    // Model: a grant occupies phases 1..5, results appear one cycle after phase 5.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase <= 0;
            m_last  <= NR - 1;
            m_id    <= 0;
            m_x     <= 0;
            m_y     <= 0;
            m_done  <= '0;
            for (int i = 0; i < NR; i++) m_tile[i] <= '0;
        end else begin
            m_done <= '0;
            if (m_phase == 0) begin
                if (req != '0) begin
                    m_id    <= pick(req, m_last);
                    m_last  <= pick(req, m_last);
                    m_x     <= int'(xtile[7*pick(req, m_last) +: 7]);
                    m_y     <= int'(ytile[7*pick(req, m_last) +: 7]);
                    m_phase <= 1;
                end
            end else if (m_phase < 5) begin
                m_phase <= m_phase + 1;
            end else begin
                m_tile[m_id] <= nb_tile(m_x, m_y);
                m_done[m_id] <= 1'b1;
                m_phase      <= 0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            int ea;
            logic [NR*8-1:0] et;
            ea = (m_phase >= 1 && m_phase <= 4) ? nb_addr(m_x, m_y, m_phase - 1) : -1;
            for (int i = 0; i < NR; i++) et[8*i +: 8] = m_tile[i];
            chk("mem_en", 64'(mem_en), 64'(ea >= 0));
            chk("mem_addr", 64'(mem_addr), (ea >= 0) ? 64'(ea) : 64'd0);
            chk("busy", 64'(busy), 64'(m_phase != 0));
            chk("done", 64'(done), 64'(m_done));
            chk("tile_info", 64'(tile_info), 64'(et));
            if (mem_en) addr_log.push_back(int'(mem_addr));
            if (cyc < 4096) en_hist[cyc] = mem_en;
            for (int i = 0; i < NR; i++) begin
                if (done[i]) begin
                    done_cyc.push_back(cyc);
                    done_id.push_back(i);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_coord(input int i, input int x, input int y);
        xtile[7*i +: 7] = 7'(x);
        ytile[7*i +: 7] = 7'(y);
    endtask

    task automatic clear_logs();
        addr_log.delete();
        done_cyc.delete();
        done_id.delete();
    endtask

    task automatic single(input int id, input int x, input int y, output int st);
        set_coord(id, x, y);
        clear_logs();
        st = cyc;
        req = NR'(1 << id);
        tick(1);
        req = '0;
        tick(8);
    endtask

    task automatic chk_addrs(input string nm, input int a0, input int a1, input int a2, input int a3);
        chk({nm, "_count"}, 64'(addr_log.size()), 64'd4);
        if (addr_log.size() == 4) begin
            chk({nm, "_rt"}, 64'(addr_log[0]), 64'(a0));
            chk({nm, "_up"}, 64'(addr_log[1]), 64'(a1));
            chk({nm, "_dn"}, 64'(addr_log[2]), 64'(a2));
            chk({nm, "_lt"}, 64'(addr_log[3]), 64'(a3));
        end
    endtask

    initial begin
        int st;
        int i;
        req   = '0;
        xtile = '0;
        ytile = '0;
        rst   = 1'b1;
        tick(2);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_mem_en", 64'(mem_en), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_tile_info", 64'(tile_info), 64'd0);
        rst = 1'b0;
        tick(1);

        single(1, 5, 10, st);
        chk_addrs("single", 306, 275, 335, 304);
        chk("single_done_count", 64'(done_id.size()), 64'd1);
        if (done_id.size() > 0) begin
            chk("single_done_id", 64'(done_id[0]), 64'd1);
            chk("single_done_cycle", 64'(done_cyc[0]), 64'(st + 6));
        end
        chk("single_tile", 64'(tile_info[15:8]), 64'h3E);

        single(0, 0, 14, st);
        chk_addrs("tunnel_left", 421, 390, 450, 449);
        single(0, 29, 14, st);
        chk("tunnel_right_rt", 64'(addr_log.size() > 0 ? addr_log[0] : -1), 64'd420);

        single(3, 10, 0, st);
        chk("top_en_rt", 64'(en_hist[st+1]), 64'd1);
        chk("top_en_up", 64'(en_hist[st+2]), 64'd0);
        chk("top_up_slot", 64'(tile_info[27:26]), 64'd0);
        single(4, 10, 32, st);
        chk("bottom_en_dn", 64'(en_hist[st+3]), 64'd0);
        chk("bottom_dn_slot", 64'(tile_info[37:36]), 64'd0);

        rst = 1'b1;
        req = '1;
        for (int k = 0; k < NR; k++) set_coord(k, k * 5 + 1, k * 6 + 2);
        tick(2);
        clear_logs();
        rst = 1'b0;
        for (i = 0; i < 60 && done_id.size() < 5; i++) tick(1);
        chk("all_done_count", 64'(done_id.size() >= 5), 64'd1);
        req = 5'b10100;
        for (i = 0; i < 80 && done_id.size() < 10; i++) tick(1);
        chk("alt_done_count", 64'(done_id.size() >= 10), 64'd1);
        if (done_id.size() >= 10) begin
            for (int k = 0; k < 5; k++) chk("rr_order", 64'(done_id[k]), 64'(k));
            for (int k = 1; k < 10; k++) chk("rr_spacing", 64'(done_cyc[k] - done_cyc[k-1]), 64'd6);
            chk("alt_0", 64'(done_id[5]), 64'd0);
            chk("alt_1", 64'(done_id[6]), 64'd2);
            chk("alt_2", 64'(done_id[7]), 64'd4);
            chk("alt_3", 64'(done_id[8]), 64'd2);
            chk("alt_4", 64'(done_id[9]), 64'd4);
        end
        req = '0;
        tick(8);

        set_coord(3, 7, 7);
        clear_logs();
        req = 5'b01000;
        tick(1);
        req = '0;
        tick(2);
        chk("pre_rst_tile_nonzero", 64'(tile_info != '0), 64'd1);
        rst = 1'b1;
        #1;
        chk("midrst_mem_en", 64'(mem_en), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_tile_info", 64'(tile_info), 64'd0);
        tick(2);
        rst = 1'b0;
        tick(10);
        chk("midrst_no_done", 64'(done_id.size()), 64'd0);
        single(3, 7, 7, st);
        chk("resume_done_count", 64'(done_id.size()), 64'd1);
        if (done_id.size() > 0) begin
            chk("resume_done_id", 64'(done_id[0]), 64'd3);
            chk("resume_done_cycle", 64'(done_cyc[0]), 64'(st + 6));
        end

        single(2, 5, 10, st);
        chk("pre_oor_tile", 64'(tile_info[23:16]), 64'h3E);
        set_coord(2, 31, 5);
        clear_logs();
        st  = cyc;
        req = 5'b00100;
        tick(2);
        req = '0;
        tick(8);
        chk("oor_no_mem_en", 64'(addr_log.size()), 64'd0);
        chk("oor_done_count", 64'(done_id.size()), 64'd1);
        if (done_id.size() > 0) begin
            chk("oor_done_id", 64'(done_id[0]), 64'd2);
            chk("oor_done_cycle", 64'(done_cyc[0]), 64'(st + 6));
        end
        chk("oor_tile", 64'(tile_info[23:16]), 64'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
